// File: rtl/decode_queue_pkg.sv
// Shared types for the multi-lane decode queue: decoded control word, queue entry, lane helpers.
package decode_queue_pkg;

    localparam int MAX_LANES  = 4;
    localparam int LANE_IDX_W = $clog2(MAX_LANES);
    localparam int LANE_CNT_W = $clog2(MAX_LANES) + 1;

    typedef logic [31:0] word_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        OP_ILLEGAL,
        OP_LUI,
        OP_AUIPC,
        OP_JAL,
        OP_JALR,
        OP_BRANCH,
        OP_LOAD,
        OP_STORE,
        OP_ALU_IMM,
        OP_ALU_REG,
        OP_FENCE,
        OP_SYSTEM
    } op_class_e;

    typedef struct packed {
        op_class_e  op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       writes_rd;
        logic       illegal_insn;
    } control_t;

    typedef struct packed {
        control_t ctrl;
        word_t    pc;
        word_t    instr;
    } dq_entry_t;

    function automatic logic [LANE_CNT_W-1:0] popcount_lanes(input logic [MAX_LANES-1:0] m);
        logic [LANE_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + LANE_CNT_W'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dq_lane_compact.sv
// Lane compaction: per-lane write offset (exclusive prefix sum of the mask) and total valid-lane count.
module dq_lane_compact
    import decode_queue_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0]                 mask,
    output logic [LANES-1:0][LANE_IDX_W-1:0] offset,
    output logic [LANE_CNT_W-1:0]            popcnt
);

    logic [MAX_LANES-1:0]  mask_ext;
    logic [LANE_CNT_W-1:0] acc;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mask_ext = '0;
        acc      = '0;
        offset   = '0;
        // NOTE: blocking '=' here builds a running sum within one evaluation; sequential state uses '<='.
        for (int i = 0; i < LANES; i++) begin
            offset[i]   = acc[LANE_IDX_W-1:0];
            acc         = acc + LANE_CNT_W'(mask[i]);
            mask_ext[i] = mask[i];
        end
        popcnt = popcount_lanes(mask_ext);
    end

endmodule

// File: rtl/scalar_decode.sv
// Single-lane combinational RV32 base decode into control_t; unknown opcodes flag illegal_insn.
module scalar_decode
    import decode_queue_pkg::*;
(
    input  word_t    instr,
    output control_t ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.rd     = instr[11:7];
        ctrl.funct3 = instr[14:12];
        ctrl.rs1    = instr[19:15];
        ctrl.rs2    = instr[24:20];
        case (instr[6:0])
            OPC_LUI:    ctrl.op = OP_LUI;
            OPC_AUIPC:  ctrl.op = OP_AUIPC;
            OPC_JAL:    ctrl.op = OP_JAL;
            OPC_JALR:   ctrl.op = OP_JALR;
            OPC_BRANCH: ctrl.op = OP_BRANCH;
            OPC_LOAD:   ctrl.op = OP_LOAD;
            OPC_STORE:  ctrl.op = OP_STORE;
            OPC_OP_IMM: ctrl.op = OP_ALU_IMM;
            OPC_OP:     ctrl.op = OP_ALU_REG;
            OPC_FENCE:  ctrl.op = OP_FENCE;
            OPC_SYSTEM: ctrl.op = OP_SYSTEM;
            default:    ctrl.op = OP_ILLEGAL;
        endcase
        ctrl.writes_rd    = ctrl.op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                                            OP_LOAD, OP_ALU_IMM, OP_ALU_REG};
        ctrl.illegal_insn = (ctrl.op == OP_ILLEGAL);
    end

endmodule

// File: rtl/multi_lane_decode_queue.sv
// Multi-lane decode + compacting FIFO draining one instruction per cycle.
// Optional same-cycle bypass when empty: define DECODE_QUEUE_BYPASS_EN.
module multi_lane_decode_queue
    import decode_queue_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_mask,
    input  logic [LANES-1:0][31:0]   in_instr,
    input  logic [LANES-1:0][31:0]   in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output control_t                 out_ctrl,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    dq_entry_t        mem_q [DEPTH];

    control_t  [LANES-1:0]                 dec_ctrl;
    dq_entry_t [LANES-1:0]                 lane_entry;
    logic      [LANES-1:0][LANE_IDX_W-1:0] lane_off;
    logic      [LANE_CNT_W-1:0]            lane_cnt;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        scalar_decode u_dec (
            .instr (in_instr[g]),
            .ctrl  (dec_ctrl[g])
        );
        assign lane_entry[g] = '{ctrl: dec_ctrl[g], pc: in_pc[g], instr: in_instr[g]};
    end

    dq_lane_compact #(.LANES(LANES)) u_compact (
        .mask   (in_mask),
        .offset (lane_off),
        .popcnt (lane_cnt)
    );

    logic                        kill, accept, fifo_valid, deq;
    logic                        bypass_valid, bypass_take;
    dq_entry_t                   bypass_entry, head;
    logic [PTR_W-1:0]            enq_n;
    logic [LANES-1:0]            wr_en;
    logic [LANES-1:0][IDX_W-1:0] wr_idx;

    // Room for a whole bundle is judged on registered occupancy only.
    assign in_ready = (DEPTH - int'(count_q)) >= LANES;

    always_comb begin
        kill       = flush | RST;
        accept     = in_valid & in_ready & ~kill;
        fifo_valid = (count_q != '0) & ~kill;

        bypass_valid = 1'b0;
        bypass_entry = '0;
`ifdef DECODE_QUEUE_BYPASS_EN
        bypass_valid = accept & (count_q == '0) & (|in_mask);
        for (int i = LANES - 1; i >= 0; i--) begin
            if (in_mask[i]) bypass_entry = lane_entry[i];
        end
`endif
        bypass_take = bypass_valid & out_ready;
        deq         = fifo_valid & out_ready;

        // A bypassed lane occupies offset 0, so the remaining lanes slide down by one.
        enq_n = accept ? (PTR_W'(lane_cnt) - PTR_W'(bypass_take)) : '0;
        for (int i = 0; i < LANES; i++) begin
            wr_en[i]  = accept & in_mask[i] & ~(bypass_take & (lane_off[i] == '0));
            wr_idx[i] = IDX_W'(wr_ptr_q + PTR_W'(lane_off[i]) - PTR_W'(bypass_take));
        end

        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + enq_n;
            rd_ptr_d = rd_ptr_q + PTR_W'(deq);
            count_d  = count_q + enq_n - PTR_W'(deq);
        end

        if (fifo_valid) begin
            head = mem_q[rd_ptr_q[IDX_W-1:0]];
        end else if (bypass_valid) begin
            head = bypass_entry;
        end else begin
            head = '0;
        end
    end

    assign out_valid = fifo_valid | bypass_valid;
    assign out_ctrl  = head.ctrl;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign count     = count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only read once count/pointers mark them written.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) mem_q[wr_idx[i]] <= lane_entry[i];
        end
    end

endmodule

// File: tb/tb_multi_lane_decode_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_multi_lane_decode_queue;
    import decode_queue_pkg::*;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       in_mask;
    logic [LANES-1:0][31:0] in_instr;
    logic [LANES-1:0][31:0] in_pc;
    logic                   out_valid;
    logic                   out_ready;
    control_t               out_ctrl;
    logic [31:0]            out_pc;
    logic [31:0]            out_instr;
    logic [CNT_W-1:0]       count;

    int n_checks = 0;
    int n_pass   = 0;
    dq_entry_t model[$];

    always #5 CLK = ~CLK;

    multi_lane_decode_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference decode from the RV32 base opcode map (bits [6:2] with [1:0]==11).
    function automatic control_t ref_decode(input word_t w);
        control_t c;
        c        = '0;
        c.rd     = w[11:7];
        c.funct3 = w[14:12];
        c.rs1    = w[19:15];
        c.rs2    = w[24:20];
        c.op     = OP_ILLEGAL;
        if (w[1:0] == 2'b11) begin
            case (w[6:2])
                5'b01101: c.op = OP_LUI;
                5'b00101: c.op = OP_AUIPC;
                5'b11011: c.op = OP_JAL;
                5'b11001: c.op = OP_JALR;
                5'b11000: c.op = OP_BRANCH;
                5'b00000: c.op = OP_LOAD;
                5'b01000: c.op = OP_STORE;
                5'b00100: c.op = OP_ALU_IMM;
                5'b01100: c.op = OP_ALU_REG;
                5'b00011: c.op = OP_FENCE;
                5'b11100: c.op = OP_SYSTEM;
                default:  c.op = OP_ILLEGAL;
            endcase
        end
        c.writes_rd    = !(c.op == OP_BRANCH || c.op == OP_STORE || c.op == OP_FENCE ||
                           c.op == OP_SYSTEM || c.op == OP_ILLEGAL);
        c.illegal_insn = (c.op == OP_ILLEGAL);
        return c;
    endfunction

    function automatic dq_entry_t ref_entry(input word_t w, input word_t pc);
        dq_entry_t e;
        e.ctrl  = ref_decode(w);
        e.pc    = pc;
        e.instr = w;
        return e;
    endfunction

    function automatic word_t rand_instr();
        logic [6:0] ops [11];
        word_t w;
        int k;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
        w = $urandom;
        k = $urandom_range(0, 13);
        if (k < 11) w[6:0] = ops[k];
        return w;
    endfunction

    task automatic idle();
        RST       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
    endtask

    task automatic set_bundle(input logic [1:0] m, input word_t i0, input word_t i1,
                              input word_t p0, input word_t p1);
        in_valid    = 1'b1;
        in_mask     = m;
        in_instr[0] = i0;
        in_instr[1] = i1;
        in_pc[0]    = p0;
        in_pc[1]    = p1;
    endtask

    // Compare the DUT against the model mid-cycle, then advance the model across the clock edge.
    task automatic cycle();
        dq_entry_t hd;
        logic      exp_v, exp_ready, kill, byp;
        @(negedge CLK);
        kill      = flush | RST;
        exp_ready = (DEPTH - model.size()) >= LANES;
        exp_v     = !kill && (model.size() > 0);
        byp       = 1'b0;
        hd        = '0;
        if (exp_v) hd = model[0];
`ifdef DECODE_QUEUE_BYPASS_EN
        if (!kill && model.size() == 0 && in_valid && exp_ready && in_mask != '0) begin
            byp   = 1'b1;
            exp_v = 1'b1;
            hd    = in_mask[0] ? ref_entry(in_instr[0], in_pc[0]) : ref_entry(in_instr[1], in_pc[1]);
        end
`endif
        check("in_ready", in_ready, exp_ready);
        check("count", count, model.size());
        check("out_valid", out_valid, exp_v);
        check("out_pc", out_pc, hd.pc);
        check("out_instr", out_instr, hd.instr);
        check("out_ctrl", out_ctrl, hd.ctrl);

        if (kill) begin
            model.delete();
        end else begin
            if (exp_v && out_ready && !byp) void'(model.pop_front());
            if (in_valid && exp_ready) begin
                bit skipped = 1'b0;
                for (int i = 0; i < LANES; i++) begin
                    if (in_mask[i]) begin
                        if (byp && out_ready && !skipped) skipped = 1'b1;
                        else model.push_back(ref_entry(in_instr[i], in_pc[i]));
                    end
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        repeat (2) cycle();
        idle();
        #1;
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_ctrl", out_ctrl, 0);

        // Fill to full with two-lane bundles, confirm a further bundle is refused, drain in order.
        for (int k = 0; k < 4; k++) begin
            set_bundle(2'b11, 32'h00500093, 32'h00A00113, 32'h1000 + 8 * k, 32'h1004 + 8 * k);
            cycle();
        end
        idle();
        #1;
        check("t1_count_full", count, 8);
        check("t1_in_ready_full", in_ready, 0);
        set_bundle(2'b11, 32'h00000013, 32'h00000013, 32'h2000, 32'h2004);
        cycle();
        idle();
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            check("t1_drain_pc", out_pc, 32'h1000 + 4 * j);
            check("t1_drain_instr", out_instr, (j % 2 == 0) ? 32'h00500093 : 32'h00A00113);
            cycle();
        end
        idle();
        #1;
        check("t1_count_empty", count, 0);

        // Only the upper lane valid.
        set_bundle(2'b10, 32'h00500093, 32'h00A00113, 32'h100, 32'h104);
        cycle();
        idle();
        #1;
        check("t2_count", count, 1);
        check("t2_out_pc", out_pc, 32'h104);
        check("t2_out_valid", out_valid, 1);
        out_ready = 1'b1;
        cycle();
        idle();

        // Steady occupancy of 6 with one enqueue and one dequeue per cycle, across pointer wrap.
        for (int k = 0; k < 3; k++) begin
            set_bundle(2'b11, rand_instr(), rand_instr(), 32'h3000 + 8 * k, 32'h3004 + 8 * k);
            cycle();
        end
        for (int k = 0; k < 12; k++) begin
            set_bundle((k % 2) ? 2'b10 : 2'b01, rand_instr(), rand_instr(),
                       32'h3100 + 8 * k, 32'h3104 + 8 * k);
            out_ready = 1'b1;
            cycle();
            check("t3_count_steady", count, 6);
        end
        for (int k = 0; k < 6; k++) begin
            set_bundle(2'b11, rand_instr(), rand_instr(), 32'h3200 + 8 * k, 32'h3204 + 8 * k);
            out_ready = 1'b1;
            cycle();
        end
        idle();
        out_ready = 1'b1;
        repeat (10) cycle();
        idle();

        // Flush, then reset, each with a bundle presented in the same cycle.
        for (int pass = 0; pass < 2; pass++) begin
            set_bundle(2'b11, 32'h00500093, 32'h00A00113, 32'h4000, 32'h4004);
            cycle();
            set_bundle(2'b11, 32'h00500093, 32'h00A00113, 32'h4008, 32'h400C);
            cycle();
            set_bundle(2'b01, 32'h00500093, 32'h00A00113, 32'h4010, 32'h4014);
            cycle();
            idle();
            #1;
            check("t4_count_before", count, 5);
            set_bundle(2'b11, 32'h00500093, 32'h00A00113, 32'h4100, 32'h4104);
            out_ready = 1'b1;
            if (pass == 0) flush = 1'b1;
            else           RST   = 1'b1;
            cycle();
            idle();
            #1;
            check(pass == 0 ? "t4_flush_count" : "t4_rst_count", count, 0);
            check(pass == 0 ? "t4_flush_valid" : "t4_rst_valid", out_valid, 0);
        end

        // Illegal encoding in lane 1 must not disturb lane 0.
        set_bundle(2'b11, 32'h00500093, 32'h00000000, 32'h500, 32'h504);
        cycle();
        idle();
        #1;
        check("t5_lane0_illegal", out_ctrl.illegal_insn, 0);
        check("t5_lane0_pc", out_pc, 32'h500);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        #1;
        check("t5_lane1_illegal", out_ctrl.illegal_insn, 1);
        check("t5_lane1_instr", out_instr, 0);
        out_ready = 1'b1;
        cycle();
        idle();

`ifdef DECODE_QUEUE_BYPASS_EN
        set_bundle(2'b11, 32'h00500093, 32'h00A00113, 32'h600, 32'h604);
        out_ready = 1'b1;
        #1;
        check("t6_bypass_valid", out_valid, 1);
        check("t6_bypass_pc", out_pc, 32'h600);
        cycle();
        idle();
        #1;
        check("t6_count", count, 1);
        check("t6_next_pc", out_pc, 32'h604);
        out_ready = 1'b1;
        cycle();
        idle();
`endif

        // Randomized traffic with occasional flush and reset.
        repeat (400) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_mask     = LANES'($urandom);
            in_instr[0] = rand_instr();
            in_instr[1] = rand_instr();
            in_pc[0]    = $urandom & 32'hFFFF_FFFC;
            in_pc[1]    = $urandom & 32'hFFFF_FFFC;
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 31) == 0);
            RST         = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle();
        out_ready = 1'b1;
        repeat (10) cycle();
        idle();
        #1;
        check("final_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
